page_walker: RTL and testbench

PAGE_WALKER -- requirements
Module: page_walker

---
 rtl/page_walker.sv | 193 +++++++++++++++++++
 tb/tb_page_walker.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/page_walker.sv
`default_nettype none
// ============================================================================
// Module      : page_walker
// Description : Hardware TLB refill walker over a single-level linear page
//               table. On a TLB miss it reads the PTE at
//               PT_BASE + {vpage,2'b00}. A valid PTE is written into the TLB
//               victim slot, which advances round-robin. An invalid PTE
//               raises a one-cycle fault pulse instead.
//               With WALKER_DIRTY_EN defined, a first store to a clean page
//               (changePageM) re-reads the PTE and writes it back with the
//               dirty bit set. It then refreshes the hit entry in the TLB.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   missM, changePageM  walk requests (miss has priority)
//   vpage, hit_index    virtual page / TLB entry of the current access
//   stallTLB            pipeline freeze while a walk is pending or running
//   mem_*               single-beat memory port, mem_ack completes a request
//   tlb_*               one-cycle TLB entry write
//   fault               one-cycle page-fault pulse
// Configuration macro: WALKER_DIRTY_EN (dirty-bit write-back walk)
// PTE format: bit31 valid, bit30 dirty, [WIDTH_PAGE-1:0] physical page
// ============================================================================
module page_walker #(
    parameter int          COUNT_STRING = 32,
    parameter int          WIDTH_PAGE   = 20,
    parameter logic [31:0] PT_BASE      = 32'h0001_0000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            missM,
    input  logic                            changePageM,
    input  logic [WIDTH_PAGE-1:0]           vpage,
    input  logic [$clog2(COUNT_STRING)-1:0] hit_index,
    output logic                            stallTLB,
    output logic                            mem_req,
    output logic                            mem_we,
    output logic [31:0]                     mem_addr,
    output logic [31:0]                     mem_wdata,
    input  logic                            mem_ack,
    input  logic [31:0]                     mem_rdata,
    output logic                            tlb_we,
    output logic [$clog2(COUNT_STRING)-1:0] tlb_index,
    output logic [WIDTH_PAGE-1:0]           tlb_vpage,
    output logic [WIDTH_PAGE-1:0]           tlb_ppage,
    output logic                            tlb_correct,
    output logic                            tlb_change,
    output logic                            fault
);

    localparam int                IDX_W      = $clog2(COUNT_STRING);
    localparam logic [IDX_W-1:0]  c_last_idx = IDX_W'(COUNT_STRING - 1);
    localparam logic [31:0]       c_dirty    = 32'h4000_0000;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        FILL   = 3'd2,
        DWRITE = 3'd3,
        FAULT  = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [WIDTH_PAGE-1:0]   r_vpage;
    logic [IDX_W-1:0]        r_hit_index;
    logic                    r_op_dirty;
    logic [31:0]             r_pte;
    logic [IDX_W-1:0]        r_victim;
    logic                    w_dirty_evt;
    logic                    w_start;
    logic [31:0]             w_pte_addr;

`ifdef WALKER_DIRTY_EN
    assign w_dirty_evt = changePageM;
`else
    // Dirty tracking compiled out: store-to-clean events are ignored.
    assign w_dirty_evt = 1'b0;
`endif

    assign w_start    = missM | w_dirty_evt;
    assign w_pte_addr = PT_BASE + 32'({r_vpage, 2'b00});

    // ------------------------------------------------------------------
    // State and walk context
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_vpage     <= '0;
            r_hit_index <= '0;
            r_op_dirty  <= 1'b0;
            r_pte       <= '0;
            r_victim    <= '0;
        end else begin
            r_state <= w_next;
            // The walk context is frozen at launch so the pipeline may change
            // vpage/hit_index while stalled.
            if (r_state == IDLE && w_start) begin
                r_vpage     <= vpage;
                r_hit_index <= hit_index;
                r_op_dirty  <= ~missM;
            end
            if (r_state == READ && mem_ack) begin
                r_pte <= mem_rdata;
            end
`ifdef WALKER_DIRTY_EN
            // Mirror the written-back dirty bit so FILL reports tlb_change=1.
            if (r_state == DWRITE && mem_ack) begin
                r_pte[30] <= 1'b1;
            end
`endif
            // Only refills consume a victim slot; dirty updates reuse the hit entry.
            if (r_state == FILL && !r_op_dirty) begin
                r_victim <= (r_victim == c_last_idx) ? '0 : r_victim + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and memory/TLB strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_next    = r_state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        tlb_we    = 1'b0;
        fault     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_next = READ;
                end
            end
            READ: begin
                mem_req  = 1'b1;
                mem_addr = w_pte_addr;
                if (mem_ack) begin
                    if (!mem_rdata[31]) begin
                        w_next = FAULT;
                    end else begin
`ifdef WALKER_DIRTY_EN
                        w_next = r_op_dirty ? DWRITE : FILL;
`else
                        w_next = FILL;
`endif
                    end
                end
            end
`ifdef WALKER_DIRTY_EN
            DWRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = w_pte_addr;
                mem_wdata = r_pte | c_dirty;
                if (mem_ack) begin
                    w_next = FILL;
                end
            end
`endif
            FILL: begin
                tlb_we = 1'b1;
                w_next = IDLE;
            end
            FAULT: begin
                fault  = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // The request terms are combinational so the stall rises in the same
    // cycle as the event. Gating with rst keeps the output low during reset.
    assign stallTLB    = rst & ((r_state != IDLE) | w_start);
    assign tlb_index   = r_op_dirty ? r_hit_index : r_victim;
    assign tlb_vpage   = r_vpage;
    assign tlb_ppage   = r_pte[WIDTH_PAGE-1:0];
    assign tlb_correct = (r_state == FILL);
    assign tlb_change  = r_pte[30];

    // PTE bits outside valid/dirty/page, and changePageM when dirty
    // tracking is compiled out, have no function here.
    logic w_unused_bits;
    assign w_unused_bits = ^{r_pte, changePageM};

endmodule
`default_nettype wire

// File: tb/tb_page_walker.sv
`default_nettype none
// ============================================================================
// Module      : tb_page_walker
// Description : Self-checking bench for page_walker. Walks are driven
//               cycle by cycle against a reference model with a page table
//               address formula, a round-robin victim count and PTE
//               valid/dirty rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_page_walker;

    localparam int          N    = 32;
    localparam int          WP   = 20;
    localparam logic [31:0] BASE = 32'h0001_0000;
`ifdef WALKER_DIRTY_EN
    localparam bit          DIRTY_ON = 1'b1;
`else
    localparam bit          DIRTY_ON = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          missM;
    logic          changePageM;
    logic [WP-1:0] vpage;
    logic [4:0]    hit_index;
    logic          stallTLB;
    logic          mem_req;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_ack;
    logic [31:0]   mem_rdata;
    logic          tlb_we;
    logic [4:0]    tlb_index;
    logic [WP-1:0] tlb_vpage;
    logic [WP-1:0] tlb_ppage;
    logic          tlb_correct;
    logic          tlb_change;
    logic          fault;

    int n_checks = 0;
    int n_errors = 0;
    int model_victim = 0;

    page_walker #(
        .COUNT_STRING (N),
        .WIDTH_PAGE   (WP),
        .PT_BASE      (BASE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .missM       (missM),
        .changePageM (changePageM),
        .vpage       (vpage),
        .hit_index   (hit_index),
        .stallTLB    (stallTLB),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .tlb_we      (tlb_we),
        .tlb_index   (tlb_index),
        .tlb_vpage   (tlb_vpage),
        .tlb_ppage   (tlb_ppage),
        .tlb_correct (tlb_correct),
        .tlb_change  (tlb_change),
        .fault       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    // Random valid PTE with a random dirty bit.
    function automatic logic [31:0] rand_valid_pte();
        logic [31:0] p;
        p     = $urandom;
        p[31] = 1'b1;
        return p;
    endfunction

    // One walk, starting #1 after a clock edge with the walker idle.
    // Each cycle is compared against the expected protocol.
    task automatic run_walk(input bit do_miss, input bit do_dirty, input logic [WP-1:0] vp,
                            input logic [4:0] hi, input logic [31:0] pte,
                            input int dly_r, input int dly_w);
        bit          dirty_walk;
        logic [31:0] exp_addr;
        logic [31:0] exp_pte;
        logic [4:0]  exp_idx;
        dirty_walk = !do_miss && do_dirty && DIRTY_ON;
        exp_addr   = BASE + 32'(vp) * 32'd4;

        missM       = do_miss;
        changePageM = do_dirty;
        vpage       = vp;
        hit_index   = hi;
        #1;
        n_checks++;
        if (stallTLB !== 1'b1) begin
            n_errors++;
            $display("FAIL stall_on_event: stallTLB=%0b, expected 1", stallTLB);
        end
        @(posedge clk); #1;
        missM       = 1'b0;
        changePageM = 1'b0;
        vpage       = WP'($urandom);
        hit_index   = 5'($urandom);

        for (int c = 0; c <= dly_r; c++) begin
            n_checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== exp_addr || stallTLB !== 1'b1) begin
                n_errors++;
                $display("FAIL read_req: req=%0b we=%0b addr=%h stall=%0b, expected req=1 we=0 addr=%h stall=1",
                         mem_req, mem_we, mem_addr, stallTLB, exp_addr);
            end
            mem_ack   = (c == dly_r);
            mem_rdata = (c == dly_r) ? pte : $urandom;
            @(posedge clk); #1;
            mem_ack = 1'b0;
        end

        if (!pte[31]) begin
            n_checks++;
            if (fault !== 1'b1 || tlb_we !== 1'b0 || mem_req !== 1'b0) begin
                n_errors++;
                $display("FAIL fault_pulse: fault=%0b tlb_we=%0b req=%0b, expected fault=1 tlb_we=0 req=0",
                         fault, tlb_we, mem_req);
            end
            @(posedge clk); #1;
            n_checks++;
            if (fault !== 1'b0 || tlb_we !== 1'b0 || stallTLB !== 1'b0) begin
                n_errors++;
                $display("FAIL fault_end: fault=%0b tlb_we=%0b stall=%0b, expected all 0",
                         fault, tlb_we, stallTLB);
            end
            return;
        end

        exp_pte = pte;
        if (dirty_walk) begin
            exp_pte = pte | 32'h4000_0000;
            for (int c = 0; c <= dly_w; c++) begin
                n_checks++;
                if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== exp_addr || mem_wdata !== exp_pte) begin
                    n_errors++;
                    $display("FAIL dirty_write: req=%0b we=%0b addr=%h wdata=%h, expected req=1 we=1 addr=%h wdata=%h",
                             mem_req, mem_we, mem_addr, mem_wdata, exp_addr, exp_pte);
                end
                mem_ack = (c == dly_w);
                @(posedge clk); #1;
                mem_ack = 1'b0;
            end
        end

        exp_idx = dirty_walk ? hi : 5'(model_victim);
        n_checks++;
        if (tlb_we !== 1'b1 || tlb_index !== exp_idx || tlb_vpage !== vp || tlb_ppage !== pte[WP-1:0] ||
            tlb_correct !== 1'b1 || tlb_change !== exp_pte[30] || mem_req !== 1'b0 || fault !== 1'b0) begin
            n_errors++;
            $display("FAIL tlb_fill: we=%0b idx=%0d vp=%h pp=%h cor=%0b chg=%0b req=%0b, expected we=1 idx=%0d vp=%h pp=%h cor=1 chg=%0b req=0",
                     tlb_we, tlb_index, tlb_vpage, tlb_ppage, tlb_correct, tlb_change, mem_req,
                     exp_idx, vp, pte[WP-1:0], exp_pte[30]);
        end
        if (!dirty_walk) model_victim = (model_victim + 1) % N;
        @(posedge clk); #1;
        n_checks++;
        if (tlb_we !== 1'b0 || stallTLB !== 1'b0) begin
            n_errors++;
            $display("FAIL fill_end: tlb_we=%0b stall=%0b, expected 0 0", tlb_we, stallTLB);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        model_victim = 0;
    endtask

    task automatic test_reset();
        rst         = 1'b0;
        missM       = 1'b1;
        changePageM = 1'b0;
        vpage       = '0;
        hit_index   = '0;
        mem_ack     = 1'b0;
        mem_rdata   = '0;
        #12;
        n_checks++;
        if ({stallTLB, mem_req, mem_we, mem_addr, mem_wdata, tlb_we, tlb_index, tlb_vpage,
             tlb_ppage, tlb_correct, tlb_change, fault} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: stall=%0b req=%0b we=%0b addr=%h wdata=%h tlb_we=%0b idx=%0d vp=%h pp=%h cor=%0b chg=%0b fault=%0b, expected all 0",
                     stallTLB, mem_req, mem_we, mem_addr, mem_wdata, tlb_we, tlb_index, tlb_vpage,
                     tlb_ppage, tlb_correct, tlb_change, fault);
        end
        missM = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        model_victim = 0;
    endtask

    task automatic test_basic_miss();
        run_walk(1'b1, 1'b0, 20'h00003, 5'd0, 32'h8000_0055, 0, 0);
    endtask

    task automatic test_victim_wrap();
        apply_reset();
        for (int i = 0; i < 33; i++) begin
            run_walk(1'b1, 1'b0, WP'($urandom), 5'($urandom), rand_valid_pte(), int'($urandom_range(0, 2)), 0);
        end
    endtask

    task automatic test_fault();
        run_walk(1'b1, 1'b0, WP'($urandom), 5'd0, rand_valid_pte(), 1, 0);
        run_walk(1'b1, 1'b0, 20'h00042, 5'd0, 32'h0000_0055, 1, 0);
        run_walk(1'b1, 1'b0, WP'($urandom), 5'd0, rand_valid_pte(), 0, 0);
    endtask

    task automatic test_dirty();
        if (DIRTY_ON) begin
            run_walk(1'b0, 1'b1, 20'h00777, 5'd5, 32'h8000_0010, 1, 1);
            run_walk(1'b1, 1'b0, WP'($urandom), 5'd0, rand_valid_pte(), 0, 0);
        end else begin
            changePageM = 1'b1;
            hit_index   = 5'd5;
            #1;
            n_checks++;
            if (stallTLB !== 1'b0) begin
                n_errors++;
                $display("FAIL dirty_ignored_stall: stallTLB=%0b, expected 0", stallTLB);
            end
            @(posedge clk); #1;
            changePageM = 1'b0;
            n_checks++;
            if (mem_req !== 1'b0 || stallTLB !== 1'b0) begin
                n_errors++;
                $display("FAIL dirty_ignored_walk: req=%0b stall=%0b, expected 0 0", mem_req, stallTLB);
            end
        end
    endtask

    task automatic test_priority();
        run_walk(1'b1, 1'b1, 20'h0ABCD, 5'd9, 32'h8001_2345, 0, 0);
    endtask

    task automatic test_idle_ack();
        mem_ack   = 1'b1;
        mem_rdata = 32'h8000_0077;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (mem_req !== 1'b0 || stallTLB !== 1'b0 || tlb_we !== 1'b0 || fault !== 1'b0) begin
                n_errors++;
                $display("FAIL idle_ack: req=%0b stall=%0b tlb_we=%0b fault=%0b, expected all 0",
                         mem_req, stallTLB, tlb_we, fault);
            end
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            bit          op_miss;
            logic [31:0] pte;
            op_miss = DIRTY_ON ? ($urandom_range(0, 2) != 0) : 1'b1;
            pte     = rand_valid_pte();
            if ($urandom_range(0, 3) == 0) pte[31] = 1'b0;
            run_walk(op_miss, !op_miss, WP'($urandom), 5'($urandom), pte,
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_reset_mid_walk();
        run_walk(1'b1, 1'b0, WP'($urandom), 5'd0, rand_valid_pte(), 0, 0);
        missM = 1'b1;
        vpage = 20'h00100;
        @(posedge clk); #1;
        missM   = 1'b0;
        mem_ack = 1'b0;
        n_checks++;
        if (mem_req !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_walk_req: req=%0b, expected 1", mem_req);
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (mem_req !== 1'b0 || stallTLB !== 1'b0 || tlb_index !== 5'd0) begin
            n_errors++;
            $display("FAIL async_reset: req=%0b stall=%0b idx=%0d, expected 0 0 0", mem_req, stallTLB, tlb_index);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        model_victim = 0;
        run_walk(1'b1, 1'b0, WP'($urandom), 5'd0, rand_valid_pte(), 1, 0);
    endtask

    initial begin
        test_reset();
        test_basic_miss();
        test_victim_wrap();
        test_fault();
        test_dirty();
        test_priority();
        test_idle_ack();
        test_random();
        test_reset_mid_walk();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
